map_checkpoint_ctrl: RTL

Allocates, tracks and retires the MAP_TABLE_DEPTH checkpoint columns of the phys reg map table for in-flight branches.
- Hands a column to each branch at dispatch; dispatch uses it to snapshot the map table.
- Frees columns in program order once their branches resolve correctly.
- On a mispredict, commands a map table restore and kills all younger checkpoints.
- Sits between dispatch, the branch resolution path, the map table and the ROB.

---
 rtl/core_types_pkg.sv | 23 ++
 rtl/checkpoint_kill_mask.sv | 26 ++
 rtl/map_checkpoint_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared core types for the map table checkpoint logic.
// Column, ROB index and checkpoint entry definitions.
package core_types_pkg;

    localparam int MAP_TABLE_DEPTH     = 4;
    localparam int LOG_MAP_TABLE_DEPTH = $clog2(MAP_TABLE_DEPTH);
    localparam int ROB_DEPTH           = 64;
    localparam int LOG_ROB_DEPTH       = $clog2(ROB_DEPTH);

    typedef logic [LOG_MAP_TABLE_DEPTH-1:0] map_table_column_index_t;
    typedef logic [LOG_ROB_DEPTH-1:0]       ROB_index_t;
    typedef logic [LOG_MAP_TABLE_DEPTH:0]   checkpoint_count_t;

    localparam checkpoint_count_t CHECKPOINT_FULL =
        checkpoint_count_t'(MAP_TABLE_DEPTH);

    typedef struct packed {
        logic       valid;
        logic       done;
        ROB_index_t ROB_index;
    } checkpoint_entry_t;

endpackage

// File: rtl/checkpoint_kill_mask.sv
// Marks the queue slots from a mispredicted column up to tail-1.
// A full queue with start == tail selects every slot.
module checkpoint_kill_mask
    import core_types_pkg::*;
(
    input  logic [LOG_MAP_TABLE_DEPTH-1:0] start_column,
    input  logic [LOG_MAP_TABLE_DEPTH-1:0] tail,
    input  logic                           full,
    output logic [MAP_TABLE_DEPTH-1:0]     kill_mask
);

    map_table_column_index_t span;
    map_table_column_index_t offset;

    // Slot i is killed when its distance from start lies inside the span
    always_comb begin
        span      = tail - start_column;
        offset    = '0;
        kill_mask = '0;
        for (int i = 0; i < MAP_TABLE_DEPTH; i++) begin
            offset       = map_table_column_index_t'(i) - start_column;
            kill_mask[i] = (offset < span) || ((span == '0) && full);
        end
    end

endmodule

// File: rtl/map_checkpoint_ctrl.sv
// Checkpoint column allocator for the phys reg map table.
// Allocates per branch, retires in order, restores on mispredict.
module map_checkpoint_ctrl
    import core_types_pkg::*;
(
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           alloc_req,
    input  logic [LOG_ROB_DEPTH-1:0]       alloc_ROB_index,
    output logic                           alloc_ready,
    output logic [LOG_MAP_TABLE_DEPTH-1:0] alloc_column,
    input  logic                           resolve_valid,
    input  logic [LOG_MAP_TABLE_DEPTH-1:0] resolve_column,
    input  logic                           resolve_mispredict,
    input  logic                           full_flush,
    output logic                           restore_valid,
    output logic [LOG_MAP_TABLE_DEPTH-1:0] restore_column,
    output logic [LOG_ROB_DEPTH-1:0]       restore_ROB_index,
    output logic [LOG_MAP_TABLE_DEPTH:0]   num_active,
    output logic                           empty
);

    checkpoint_entry_t       q   [MAP_TABLE_DEPTH];
    checkpoint_entry_t       q_n [MAP_TABLE_DEPTH];
    map_table_column_index_t head, head_n;
    map_table_column_index_t tail, tail_n;
    checkpoint_count_t       count, count_n;

    checkpoint_entry_t           res_entry;
    logic                        mispredict_fire;
    logic                        correct_fire;
    logic                        retire_fire;
    logic                        head_kill;
    logic                        alloc_fire;
    logic [MAP_TABLE_DEPTH-1:0]  kill_mask;

    assign alloc_column = tail;
    assign num_active   = count;
    assign empty        = (count == '0);

    checkpoint_kill_mask u_kill_mask (
        .start_column (resolve_column),
        .tail         (tail),
        .full         (count == CHECKPOINT_FULL),
        .kill_mask    (kill_mask)
    );

    // Qualify resolve, retire and allocate events against current state
    always_comb begin
        res_entry       = q[resolve_column];
        mispredict_fire = resolve_valid && resolve_mispredict
                          && res_entry.valid && !res_entry.done;
        correct_fire    = resolve_valid && !resolve_mispredict
                          && res_entry.valid && !res_entry.done;
        retire_fire     = q[head].valid && q[head].done;
        head_kill       = mispredict_fire && (resolve_column == head);
        alloc_ready     = (count != CHECKPOINT_FULL) && !restore_valid
                          && !(resolve_valid && resolve_mispredict)
                          && !full_flush;
        alloc_fire      = alloc_req && alloc_ready;
    end

    // Next queue state: retire, then kill or resolve/allocate
    always_comb begin
        q_n     = q;
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        if (retire_fire && !head_kill) begin
            q_n[head] = '0;
            head_n    = head + 1'b1;
            count_n   = count - 1'b1;
        end
        if (mispredict_fire) begin
            for (int i = 0; i < MAP_TABLE_DEPTH; i++) begin
                if (kill_mask[i]) begin
                    q_n[i] = '0;
                end
            end
            tail_n  = resolve_column;
            count_n = {1'b0, map_table_column_index_t'(resolve_column - head_n)};
        end else begin
            if (correct_fire) begin
                q_n[resolve_column].done = 1'b1;
            end
            if (alloc_fire) begin
                q_n[tail].valid     = 1'b1;
                q_n[tail].done      = 1'b0;
                q_n[tail].ROB_index = alloc_ROB_index;
                tail_n              = tail + 1'b1;
                count_n             = count_n + 1'b1;
            end
        end
    end

    // Queue registers and the one-cycle restore command
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < MAP_TABLE_DEPTH; i++) begin
                q[i] <= '0;
            end
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            restore_valid     <= 1'b0;
            restore_column    <= '0;
            restore_ROB_index <= '0;
        end else if (full_flush) begin
            for (int i = 0; i < MAP_TABLE_DEPTH; i++) begin
                q[i] <= '0;
            end
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            restore_valid     <= 1'b0;
            restore_column    <= '0;
            restore_ROB_index <= '0;
        end else begin
            for (int i = 0; i < MAP_TABLE_DEPTH; i++) begin
                q[i] <= q_n[i];
            end
            head          <= head_n;
            tail          <= tail_n;
            count         <= count_n;
            restore_valid <= mispredict_fire;
            if (mispredict_fire) begin
                restore_column    <= resolve_column;
                restore_ROB_index <= res_entry.ROB_index;
            end
        end
    end

endmodule
